// File: rtl/spm_seq.sv
`default_nettype none
// ============================================================================
//  Module      : spm_seq
//  Description : Sequencer for a serial-parallel multiplier. Accepts a signed
//                operand pair, clears the multiplier, streams the sign-extended
//                multiplier LSB-first, and assembles the 2*WIDTH-bit product.
//  Revision    : 1.0  initial release
// ============================================================================
module spm_seq #(
   parameter int WIDTH      = 8,
   parameter int CLR_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_valid,
   output logic                 start_ready,
   input  logic [WIDTH-1:0]     mc,
   input  logic [WIDTH-1:0]     mp,
   output logic                 spm_rst,
   output logic [WIDTH-1:0]     spm_x,
   output logic                 spm_y,
   input  logic                 spm_p,
   output logic [2*WIDTH-1:0]   prod,
   output logic                 prod_valid,
   input  logic                 prod_ready,
   output logic                 busy
);

   localparam int c_prod_w  = 2 * WIDTH;
   // One counter serves both the clear phase and the shift phase.
   localparam int c_cnt_max = (c_prod_w > CLR_CYCLES) ? c_prod_w : CLR_CYCLES;
   localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
   localparam logic [c_cnt_w-1:0] c_shift_last = c_cnt_w'(c_prod_w);
   localparam logic [c_cnt_w-1:0] c_clr_last   = c_cnt_w'(CLR_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [c_cnt_w-1:0]    r_cnt;
   logic [c_prod_w-1:0]   r_mp_sr;
   logic                  w_take;

   assign w_take = start_valid & start_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_take)               w_next = CLEAR;
         CLEAR:   if (r_cnt == c_clr_last)  w_next = SHIFT;
         SHIFT:   if (r_cnt == c_shift_last) w_next = DONE;
         DONE:    if (prod_ready)           w_next = IDLE;
         default:                           w_next = IDLE;
      endcase
   end

   // Registered outputs and datapath; status flags are derived from the
   // next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         start_ready <= 1'b1;
         busy        <= 1'b0;
         spm_rst     <= 1'b1;
         prod_valid  <= 1'b0;
         prod        <= '0;
         spm_x       <= '0;
         spm_y       <= 1'b0;
         r_cnt       <= '0;
         r_mp_sr     <= '0;
      end else begin
         start_ready <= (w_next == IDLE);
         busy        <= (w_next != IDLE);
         spm_rst     <= (w_next != SHIFT);
         prod_valid  <= (w_next == DONE);
         case (r_state)
            IDLE: begin
               spm_y <= 1'b0;
               if (w_take) begin
                  spm_x   <= mc;
                  r_mp_sr <= {{WIDTH{mp[WIDTH-1]}}, mp};
                  r_cnt   <= '0;
               end
            end
            CLEAR: begin
               spm_y <= 1'b0;
               if (r_cnt == c_clr_last) begin
                  // Present multiplier bit 0 for the first SHIFT cycle.
                  r_cnt   <= '0;
                  spm_y   <= r_mp_sr[0];
                  r_mp_sr <= r_mp_sr >> 1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            SHIFT: begin
               // Zero fill means spm_y is 0 once every multiplier bit is out.
               spm_y   <= r_mp_sr[0];
               r_mp_sr <= r_mp_sr >> 1;
               // spm_p lags spm_y by one cycle, so collection starts at cnt=1.
               if (r_cnt != '0) begin
                  prod <= {spm_p, prod[c_prod_w-1:1]};
               end
               if (r_cnt != c_shift_last) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               spm_y <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spm_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spm_seq
//  Description : Directed and random self-checking bench for spm_seq with a
//                behavioural serial-parallel multiplier attached.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spm_seq;

   logic        clk;
   logic        rst;
   logic        start_valid;
   logic        start_ready;
   logic [7:0]  mc;
   logic [7:0]  mp;
   logic        spm_rst;
   logic [7:0]  spm_x;
   logic        spm_y;
   logic        spm_p;
   logic [15:0] prod;
   logic        prod_valid;
   logic        prod_ready;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   spm_seq #(.WIDTH(8), .CLR_CYCLES(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .mc          (mc),
      .mp          (mp),
      .spm_rst     (spm_rst),
      .spm_x       (spm_x),
      .spm_y       (spm_y),
      .spm_p       (spm_p),
      .prod        (prod),
      .prod_valid  (prod_valid),
      .prod_ready  (prod_ready),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural serial-parallel multiplier: adds x when y is set, emits the
   // LSB as a registered product bit, then shifts the partial sum right.
   int acc;
   always @(posedge clk) begin
      int t;
      if (spm_rst) begin
         acc   <= 0;
         spm_p <= 1'b0;
      end else begin
         t = acc + (spm_y ? int'($signed(spm_x)) : 0);
         spm_p <= t[0];
         acc   <= t >>> 1;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Offer an operand pair at a negedge once start_ready is seen; returns at
   // the negedge after the accepting edge.
   task automatic start_op(input string tag, input logic [7:0] a, input logic [7:0] b);
      int w;
      w = 0;
      while (!start_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) check({tag, " start_ready timeout"}, 32'(start_ready), 32'd1);
      mc          = a;
      mp          = b;
      start_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input logic [15:0] exp, input int hold,
                              input bit pulse, input bit chk_lat);
      int lat;
      bit stable;
      lat    = 0;
      stable = 1'b1;
      while (!prod_valid && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (pulse) begin
            if (lat == 5) begin
               start_valid = 1'b1;
               mc          = 8'h7F;
               mp          = 8'h80;
            end else begin
               start_valid = 1'b0;
            end
         end
      end
      if (chk_lat) check({tag, " latency"}, 32'(lat), 32'd18);
      check({tag, " prod"}, 32'(prod), 32'(exp));
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!(prod_valid === 1'b1 && prod === exp)) stable = 1'b0;
         end
         check({tag, " held stable"}, 32'(stable), 32'd1);
         prod_ready = 1'b1;
      end
      @(negedge clk);
      check({tag, " valid drop"}, 32'(prod_valid), 32'd0);
      check({tag, " ready back"}, 32'(start_ready), 32'd1);
      if (hold > 0) check({tag, " prod kept"}, 32'(prod), 32'(exp));
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [15:0] rexp;
      bit         seen;

      rst         = 1'b0;
      start_valid = 1'b0;
      mc          = 8'h00;
      mp          = 8'h00;
      prod_ready  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst start_ready", 32'(start_ready), 32'd1);
      check("rst busy",        32'(busy),        32'd0);
      check("rst prod_valid",  32'(prod_valid),  32'd0);
      check("rst prod",        32'(prod),        32'd0);
      check("rst spm_x",       32'(spm_x),       32'd0);
      check("rst spm_y",       32'(spm_y),       32'd0);
      check("rst spm_rst",     32'(spm_rst),     32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("idle spm_rst", 32'(spm_rst), 32'd1);

      // Basic signed products and boundary operands.
      start_op("3x5", 8'd3, 8'd5);
      check("3x5 busy", 32'(busy), 32'd1);
      wait_result("3x5", 16'h000F, 0, 1'b0, 1'b1);
      start_op("-3x5", 8'hFD, 8'd5);
      wait_result("-3x5", 16'hFFF1, 0, 1'b0, 1'b1);
      start_op("-128x-128", 8'h80, 8'h80);
      wait_result("-128x-128", 16'h4000, 0, 1'b0, 1'b1);
      start_op("127x-128", 8'h7F, 8'h80);
      wait_result("127x-128", 16'hC080, 0, 1'b0, 1'b1);

      // Consumer back-pressure for 10 cycles.
      prod_ready = 1'b0;
      start_op("hold", 8'hF6, 8'h0C);
      wait_result("hold", 16'hFF88, 10, 1'b0, 1'b1);

      // New operands offered mid-operation must be ignored.
      start_op("pulse", 8'h12, 8'h34);
      wait_result("pulse", 16'h03A8, 0, 1'b1, 1'b1);
      check("pulse spm_x kept", 32'(spm_x), 32'h12);

      // Abort with reset while cnt=7 in SHIFT.
      start_op("abort", 8'h55, 8'h33);
      repeat (8) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort prod_valid", 32'(prod_valid), 32'd0);
      check("abort spm_rst",    32'(spm_rst),    32'd1);
      check("abort busy",       32'(busy),       32'd0);
      check("abort start_ready", 32'(start_ready), 32'd1);
      rst  = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (prod_valid) seen = 1'b1;
      end
      check("abort no valid", 32'(seen), 32'd0);
      start_op("7x-1", 8'd7, 8'hFF);
      wait_result("7x-1", 16'hFFF9, 0, 1'b0, 1'b1);

      // Back-to-back random signed operands.
      for (int n = 0; n < 1000; n++) begin
         ra   = 8'($urandom_range(0, 255));
         rb   = 8'($urandom_range(0, 255));
         rexp = 16'($signed(ra) * $signed(rb));
         start_op("rand", ra, rb);
         wait_result("rand", rexp, 0, 1'b0, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
